// File: rtl/alu_seq_exec.sv
// alu_seq_exec: multi-cycle ALU execute unit with valid/ready on both sides.
// Non-shift ops finish in one cycle; shifts move one bit per cycle unless
// ALU_FAST_SHIFT_EN is defined, which swaps in a single-cycle barrel shifter.
// Results are identical in both builds; only shift latency differs.
module alu_seq_exec #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            operation,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  illegal
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_EQ   = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_SLT2 = 4'b1100;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                  state, state_nx;
    logic [3:0]              op_q;
    logic [SHAMT_W-1:0]      count;
    logic [DATA_WIDTH-1:0]   res_q;
    logic                    ill_q;

    logic [SHAMT_W-1:0]      shamt;
    logic                    is_shift;
    logic                    go_shift;
    logic [DATA_WIDTH-1:0]   imm_res;
    logic                    imm_ill;
    logic [DATA_WIDTH-1:0]   shift_one;

    assign shamt    = b[SHAMT_W-1:0];
    assign is_shift = (operation == OP_SLL) || (operation == OP_SRL) || (operation == OP_SRA);

`ifdef ALU_FAST_SHIFT_EN
    assign go_shift = 1'b0;
`else
    // shamt==0 completes directly in IDLE with the unshifted operand
    assign go_shift = is_shift && (shamt != '0);
`endif

    // Single-cycle result for everything that does not iterate
    always_comb begin
        imm_res = '0;
        imm_ill = 1'b0;
        case (operation)
            OP_AND:          imm_res = a & b;
            OP_OR:           imm_res = a | b;
            OP_ADD:          imm_res = a + b;
            OP_XOR:          imm_res = a ^ b;
            OP_SUB:          imm_res = a - b;
            OP_SLT, OP_SLT2: imm_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_EQ:           imm_res = {{(DATA_WIDTH-1){1'b0}}, (a == b)};
`ifdef ALU_FAST_SHIFT_EN
            OP_SLL:          imm_res = a << shamt;
            OP_SRL:          imm_res = a >> shamt;
            OP_SRA:          imm_res = $signed(a) >>> shamt;
`else
            OP_SLL, OP_SRL, OP_SRA: imm_res = a;
`endif
            default:         imm_ill = 1'b1;
        endcase
    end

    // One-bit step of the iterative shifter; SRA replicates the sign bit
    always_comb begin
        shift_one = res_q;
        case (op_q)
            OP_SLL:  shift_one = {res_q[DATA_WIDTH-2:0], 1'b0};
            OP_SRL:  shift_one = {1'b0, res_q[DATA_WIDTH-1:1]};
            default: shift_one = {res_q[DATA_WIDTH-1], res_q[DATA_WIDTH-1:1]};
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state: accept in IDLE, iterate in SHIFT, hold in DONE until taken
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = go_shift ? SHIFT : DONE;
            SHIFT:   if (count == SHAMT_W'(1)) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: res_q doubles as the shift register while iterating
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q  <= '0;
            count <= '0;
            res_q <= '0;
            ill_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q <= operation;
                        if (go_shift) begin
                            res_q <= a;
                            count <= shamt;
                            ill_q <= 1'b0;
                        end else begin
                            res_q <= imm_res;
                            ill_q <= imm_ill;
                        end
                    end
                end
                SHIFT: begin
                    res_q <= shift_one;
                    count <= count - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = res_q;
    assign zero      = (res_q == '0);
    assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: directed spec vectors plus randomized ops, checked against
// an arithmetic reference model by a per-cycle compare process.
module tb_alu_seq_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  operation;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int ncmp  = 0;
    int nfail = 0;

    logic        exp_valid = 1'b0;
    logic [31:0] exp_res;
    logic        exp_ill;

    alu_seq_exec #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .operation(operation), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        ncmp++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %h want %h", nm, act, expv);
        end
    endtask

    // Reference model: what the op computes, from plain arithmetic
    function automatic void model(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] r, output logic il);
        int sh;
        sh = int'(bv[4:0]);
        il = 1'b0;
        r  = 32'h0;
        case (op)
            4'd0:        r = av & bv;
            4'd1:        r = av | bv;
            4'd2:        r = av + bv;
            4'd3:        r = av ^ bv;
            4'd4:        r = av << sh;
            4'd5:        r = av >> sh;
            4'd6:        r = av - bv;
            4'd7, 4'd12: r = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
            4'd8:        r = (av == bv) ? 32'd1 : 32'd0;
            4'd9:        r = $signed(av) >>> sh;
            default:     il = 1'b1;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [31:0] bv);
`ifdef ALU_FAST_SHIFT_EN
        model_lat = 1;
`else
        if (op == 4'd4 || op == 4'd5 || op == 4'd9) model_lat = 1 + int'(bv[4:0]);
        else                                         model_lat = 1;
`endif
    endfunction

    // Compare process: whenever a result is presented it must match the model
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (!exp_valid) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                check("result", result, exp_res);
                check("zero", {31'd0, zero}, {31'd0, (exp_res == 32'd0)});
                check("illegal", {31'd0, illegal}, {31'd0, exp_ill});
            end
        end
    end

    // Issue one op, check latency, hold the result for 'hold' cycles, then take it.
    // Enters and leaves just after a posedge.
    task automatic do_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input int hold, output logic [31:0] r, output logic z, output logic il);
        int lat;
        logic [31:0] mr;
        logic        mi;
        in_valid  = 1'b1;
        operation = op;
        a         = av;
        b         = bv;
        @(negedge clk);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model(op, av, bv, mr, mi);
        exp_res   = mr;
        exp_ill   = mi;
        exp_valid = 1'b1;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check("timeout_out_valid", 32'd0, 32'd1);
        check("latency", lat, model_lat(op, bv));
        r  = result;
        z  = zero;
        il = illegal;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        exp_valid = 1'b0;
        @(negedge clk);
        check("post_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] r, mr;
        logic        z, il, mi;
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        // Pin the model with hand-computed values
        model(4'd2, 32'h7FFFFFFF, 32'd1, mr, mi);  check("model_add", mr, 32'h80000000);
        model(4'd9, 32'h80000000, 32'd31, mr, mi); check("model_sra", mr, 32'hFFFFFFFF);
        model(4'd7, 32'hFFFFFFFF, 32'd1, mr, mi);  check("model_slt", mr, 32'd1);
        model(4'd15, 32'd7, 32'd7, mr, mi);        check("model_ill", {31'd0, mi}, 32'd1);

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        operation = 4'd0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        @(posedge clk);
        #1;

        // Directed vectors
        do_op(4'd2, 32'h7FFFFFFF, 32'd1, 0, r, z, il);
        check("add_res", r, 32'h80000000); check("add_zero", {31'd0, z}, 32'd0);
        do_op(4'd6, 32'd5, 32'd5, 0, r, z, il);
        check("sub_res", r, 32'd0); check("sub_zero", {31'd0, z}, 32'd1);
        do_op(4'd8, 32'd3, 32'd3, 0, r, z, il);
        check("eq_res", r, 32'd1); check("eq_zero", {31'd0, z}, 32'd0);
        do_op(4'd7, 32'hFFFFFFFF, 32'd1, 0, r, z, il);  check("slt_res", r, 32'd1);
        do_op(4'd12, 32'hFFFFFFFF, 32'd1, 0, r, z, il); check("slt2_res", r, 32'd1);
        do_op(4'd7, 32'd1, 32'hFFFFFFFF, 0, r, z, il);  check("slt_neg_res", r, 32'd0);
        do_op(4'd9, 32'h80000000, 32'd31, 0, r, z, il); check("sra_res", r, 32'hFFFFFFFF);
        do_op(4'd5, 32'h80000000, 32'd31, 0, r, z, il); check("srl_res", r, 32'd1);
        do_op(4'd4, 32'd1, 32'h20, 5, r, z, il);        check("sll0_res", r, 32'd1);

        // Reset in the middle of SLL by 10
        in_valid = 1'b1; operation = 4'd4; a = 32'd1; b = 32'd10;
        @(posedge clk);
        #1 in_valid = 1'b0;
        exp_res = 32'd1024; exp_ill = 1'b0; exp_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_valid = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_result", result, 32'd0);
        check("midrst_zero", {31'd0, zero}, 32'd1);
        @(posedge clk);
        #1;
        do_op(4'd15, 32'h1234, 32'h5678, 0, r, z, il);
        check("ill_flag", {31'd0, il}, 32'd1); check("ill_res", r, 32'd0);

        // Randomized ops
        for (int n = 0; n < 200; n++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 7) == 0) ra = rb;
            do_op(rop, ra, rb, $urandom_range(0, 2), r, z, il);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
